// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter sharing the single register-file write
// port among four requesters (writeback, load return, link write, debug poke).
// A winner is picked each cycle and the register file sees registered write
// controls plus a one-cycle grant pulse back to the winner.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   req            request vector, bit i = requester i
//   req_addr       requester i address at [i*ADDR_W +: ADDR_W]
//   req_data       requester i data at [i*DATA_W +: DATA_W]
//   stall          suppresses new grants this cycle
//   gnt            one-hot grant pulse (registered)
//   rf_write       register-file write enable (registered)
//   rf_writeregsel register-file write address (registered)
//   rf_writedata   register-file write data (registered)
//   err            sticky requester protocol-error flag
module rf_write_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_addr,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic                  stall,
  output logic [3:0]            gnt,
  output logic                  rf_write,
  output logic [ADDR_W-1:0]     rf_writeregsel,
  output logic [DATA_W-1:0]     rf_writedata,
  output logic                  err
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned PTR_W = 2;

  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [ADDR_W-1:0] cap_addr_q [N_REQ];
  logic [ADDR_W-1:0] cap_addr_d [N_REQ];
  logic [DATA_W-1:0] cap_data_q [N_REQ];
  logic [DATA_W-1:0] cap_data_d [N_REQ];

  logic [N_REQ-1:0]  elig;
  logic              found;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  idx;
  logic [N_REQ-1:0]  win_oh;
  logic              fault;
  logic [ADDR_W-1:0] slice_addr;
  logic [DATA_W-1:0] slice_data;

  // Winner search from ptr upward with wrap; the current grant is masked so a
  // requester still holding req during its grant cycle is not granted twice.
  always_comb begin
    elig    = req & ~gnt_q;
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    if (!stall) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = ptr_q + PTR_W'(k);
        if (!found && elig[idx]) begin
          found   = 1'b1;
          win_idx = idx;
        end
      end
    end
    win_oh = found ? (N_REQ'(1) << win_idx) : '0;
  end

  // Next-state for write controls, pointer, pending tracking and error flag.
  always_comb begin
    gnt_d      = win_oh;
    rf_write_d = found;
    sel_d      = sel_q;
    data_d     = data_q;
    ptr_d      = ptr_q;
    pend_d     = pend_q;
    fault      = 1'b0;
    slice_addr = '0;
    slice_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cap_addr_d[i] = cap_addr_q[i];
      cap_data_d[i] = cap_data_q[i];
    end

    if (found) begin
      sel_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
      data_d = req_data[win_idx*DATA_W +: DATA_W];
      ptr_d  = win_idx + PTR_W'(1);
    end

    for (int unsigned i = 0; i < N_REQ; i++) begin
      slice_addr = req_addr[i*ADDR_W +: ADDR_W];
      slice_data = req_data[i*DATA_W +: DATA_W];
      // A waiting requester must keep req high and its payload stable.
      if (pend_q[i] && (!req[i] || (slice_addr != cap_addr_q[i]) ||
                        (slice_data != cap_data_q[i]))) begin
        fault = 1'b1;
      end
      // The grant-cycle hold (gnt_q set) is not a new wait.
      if (win_oh[i]) begin
        pend_d[i] = 1'b0;
      end else if (req[i] && !gnt_q[i] && !pend_q[i]) begin
        pend_d[i]     = 1'b1;
        cap_addr_d[i] = slice_addr;
        cap_data_d[i] = slice_data;
      end
    end

    err_d = err_q | fault;
  end

  // State registers; reset drops any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= '0;
      rf_write_q <= 1'b0;
      sel_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      ptr_q      <= '0;
      pend_q     <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cap_addr_q[i] <= '0;
        cap_data_q[i] <= '0;
      end
    end else begin
      gnt_q      <= gnt_d;
      rf_write_q <= rf_write_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cap_addr_q[i] <= cap_addr_d[i];
        cap_data_q[i] <= cap_data_d[i];
      end
    end
  end

  assign gnt            = gnt_q;
  assign rf_write       = rf_write_q;
  assign rf_writeregsel = sel_q;
  assign rf_writedata   = data_q;
  assign err            = err_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by a
// randomized protocol-compliant phase, all checked against a behavioural model.
module tb_rf_write_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  logic                clk;
  logic                rst;
  logic [3:0]          req;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_data;
  logic                stall;
  logic [3:0]          gnt;
  logic                rf_write;
  logic [ADDR_W-1:0]   rf_writeregsel;
  logic [DATA_W-1:0]   rf_writedata;
  logic                err;

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .stall          (stall),
    .gnt            (gnt),
    .rf_write       (rf_write),
    .rf_writeregsel (rf_writeregsel),
    .rf_writedata   (rf_writedata),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int                m_ptr;
  logic [3:0]        m_gnt;
  logic              m_wr;
  logic [ADDR_W-1:0] m_sel;
  logic [DATA_W-1:0] m_data;
  logic              m_err;
  bit                m_pend  [4];
  logic [ADDR_W-1:0] m_cap_a [4];
  logic [DATA_W-1:0] m_cap_d [4];

  // Requester driver state
  bit act [4];
  bit rel [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit on, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req[i] = on;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Applies the arbitration rules to the inputs present at this edge.
  task automatic model_edge();
    bit fault;
    int w;
    int j;
    if (rst) begin
      m_ptr = 0; m_gnt = '0; m_wr = 1'b0; m_sel = '0; m_data = '0; m_err = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 1'b0; m_cap_a[i] = '0; m_cap_d[i] = '0;
      end
    end else begin
      fault = 1'b0;
      for (int i = 0; i < 4; i++)
        if (m_pend[i] && (!req[i] || req_addr[i*ADDR_W +: ADDR_W] !== m_cap_a[i] ||
                          req_data[i*DATA_W +: DATA_W] !== m_cap_d[i]))
          fault = 1'b1;
      w = -1;
      if (!stall)
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (w < 0 && req[j] && !m_gnt[j]) w = j;
        end
      for (int i = 0; i < 4; i++) begin
        if (i == w) m_pend[i] = 1'b0;
        else if (req[i] && !m_gnt[i] && !m_pend[i]) begin
          m_pend[i]  = 1'b1;
          m_cap_a[i] = req_addr[i*ADDR_W +: ADDR_W];
          m_cap_d[i] = req_data[i*DATA_W +: DATA_W];
        end
      end
      if (w >= 0) begin
        m_gnt  = 4'b0001 << w;
        m_wr   = 1'b1;
        m_sel  = req_addr[w*ADDR_W +: ADDR_W];
        m_data = req_data[w*DATA_W +: DATA_W];
        m_ptr  = (w + 1) % 4;
      end else begin
        m_gnt = '0;
        m_wr  = 1'b0;
      end
      m_err = m_err | fault;
    end
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("rf_write", 32'(rf_write), 32'(m_wr));
    chk("rf_writeregsel", 32'(rf_writeregsel), 32'(m_sel));
    chk("rf_writedata", 32'(rf_writedata), 32'(m_data));
    chk("err", 32'(err), 32'(m_err));
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Protocol-compliant requesters: hold through the grant cycle, then either
  // re-request with fresh payload or drop.
  task automatic drive_reqs(input int p_new, input bit rereq);
    for (int i = 0; i < 4; i++) begin
      if (rel[i]) begin
        rel[i] = 1'b0;
        if (rereq || $urandom_range(99) < p_new) begin
          set_req(i, 1'b1, ADDR_W'($urandom), DATA_W'($urandom));
        end else begin
          act[i] = 1'b0;
          set_req(i, 1'b0, '0, '0);
        end
      end else if (act[i]) begin
        if (m_gnt[i]) rel[i] = 1'b1;
      end else if ($urandom_range(99) < p_new) begin
        act[i] = 1'b1;
        set_req(i, 1'b1, ADDR_W'($urandom), DATA_W'($urandom));
      end
    end
  endtask

  task automatic clear_reqs();
    req = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < 4; i++) begin
      act[i] = 1'b0; rel[i] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    clear_reqs();

    // Reset and idle
    step(); step();
    chk("reset_rf_write", 32'(rf_write), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_gnt", 32'(gnt), 32'd0);
    end

    // Single request
    set_req(0, 1'b1, 3'd5, 16'hBEEF);
    step();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_sel", 32'(rf_writeregsel), 32'd5);
    chk("single_data", 32'(rf_writedata), 32'hBEEF);
    step();
    chk("single_gnt_once", 32'(gnt), 32'd0);
    set_req(0, 1'b0, '0, '0);
    step();

    // Walk ptr to 3, then a lone request at index 0 must wrap
    set_req(1, 1'b1, 3'd1, 16'h1111);
    step(); chk("walk1_gnt", 32'(gnt), 32'h2);
    step(); set_req(1, 1'b0, '0, '0);
    set_req(2, 1'b1, 3'd2, 16'h2222);
    step(); chk("walk2_gnt", 32'(gnt), 32'h4);
    step(); set_req(2, 1'b0, '0, '0);
    set_req(0, 1'b1, 3'd7, 16'h0A0A);
    step(); chk("wrap_gnt", 32'(gnt), 32'h1);
    step(); set_req(0, 1'b0, '0, '0);
    step();

    // Full contention starting from ptr = 1
    for (int i = 0; i < 4; i++) begin
      act[i] = 1'b1;
      set_req(i, 1'b1, ADDR_W'(i), DATA_W'(16'hC000 + i));
    end
    for (int k = 0; k < 16; k++) begin
      step();
      chk("rotate_gnt", 32'(gnt), 32'(4'b0001 << ((1 + k) % 4)));
      drive_reqs(100, 1'b1);
    end
    clear_reqs();
    step(); step();

    // Stall with two requesters, from ptr = 0
    rst = 1'b1; step(); rst = 1'b0;
    set_req(1, 1'b1, 3'd3, 16'h0101);
    set_req(2, 1'b1, 3'd4, 16'h0202);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_gnt", 32'(gnt), 32'd0);
      chk("stall_wr", 32'(rf_write), 32'd0);
    end
    stall = 1'b0;
    step(); chk("post_stall_gnt1", 32'(gnt), 32'h2);
    step(); chk("post_stall_gnt2", 32'(gnt), 32'h4);
    set_req(1, 1'b0, '0, '0);
    step(); set_req(2, 1'b0, '0, '0);
    chk("stall_err", 32'(err), 32'd0);

    // Protocol error: requester 1 withdraws while pending
    set_req(0, 1'b1, 3'd1, 16'hAAAA);
    set_req(1, 1'b1, 3'd2, 16'h5555);
    step(); chk("perr_gnt0", 32'(gnt), 32'h1);
    set_req(1, 1'b0, '0, '0);
    step(); chk("perr_err_set", 32'(err), 32'd1);
    set_req(0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      step(); chk("perr_err_sticky", 32'(err), 32'd1);
    end
    rst = 1'b1; step(); rst = 1'b0;
    chk("perr_err_cleared", 32'(err), 32'd0);

    // Reset arriving on the edge that would grant
    set_req(3, 1'b1, 3'd6, 16'h3333);
    rst = 1'b1;
    step(); chk("rst_mid_grant", 32'(rf_write), 32'd0);
    rst = 1'b0;
    clear_reqs();
    step();

    // Randomized traffic with stalls and occasional resets
    for (int k = 0; k < 400; k++) begin
      stall = ($urandom_range(7) == 0);
      rst   = ($urandom_range(63) == 0);
      step();
      drive_reqs(40, 1'b0);
    end
    rst = 1'b0; stall = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
